// File: rtl/fc_layer_par.sv
// Multi-lane fully-connected layer: y = post(W*x + b), LANES neurons accumulated per group.
// Streams x/W/b from synchronous memories of latency RD_LAT and writes one neuron per cycle.
module fc_layer_par #(
  parameter int IN_DIM  = 784,
  parameter int OUT_DIM = 32,
  parameter int LANES   = 4,
  parameter int DW      = 8,
  parameter int BW      = 32,
  parameter int ACC_W   = 32,
  parameter int RD_LAT  = 1,
  localparam int G      = OUT_DIM / LANES,
  localparam int XAW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1,
  localparam int WAW    = (G * IN_DIM > 1) ? $clog2(G * IN_DIM) : 1,
  localparam int GW     = (G > 1) ? $clog2(G) : 1,
  localparam int YAW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  relu_en,
  input  logic                  round_en,
  input  logic [5:0]            shift_right,
  output logic                  busy,
  output logic                  done,
  output logic [XAW-1:0]        x_addr,
  input  logic [DW-1:0]         x_data,
  output logic [WAW-1:0]        w_addr,
  input  logic [LANES*DW-1:0]   w_data,
  output logic [GW-1:0]         b_addr,
  input  logic [LANES*BW-1:0]   b_data,
  output logic                  y_we,
  output logic [YAW-1:0]        y_addr,
  output logic [DW-1:0]         y_data
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(IN_DIM + RD_LAT + 1);
  localparam int EW = ACC_W + 1;

  localparam logic [CW-1:0] BIAS_LAST = CW'(RD_LAT);
  localparam logic [CW-1:0] MAC_LAST  = CW'(IN_DIM + RD_LAT - 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(IN_DIM - 1);
  localparam logic [CW-1:0] RDL       = CW'(RD_LAT);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [GW-1:0] G_LAST    = GW'(G - 1);
  localparam logic signed [EW-1:0] Y_MAX = EW'(2 ** (DW - 1) - 1);
  localparam logic signed [EW-1:0] Y_MIN = -(EW'(2 ** (DW - 1)));

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_WRITE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]            cnt;
  logic [LW-1:0]            lane;
  logic [GW-1:0]            g;
  logic                     relu_q, round_q;
  logic [5:0]               shift_q;
  logic signed [ACC_W-1:0]  acc [LANES];
  logic signed [2*DW-1:0]   prod [LANES];

  logic signed [ACC_W-1:0]  acc_sel;
  logic signed [EW-1:0]     ext, rnd, shf;
  logic signed [DW-1:0]     post_y;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BIAS;
      S_BIAS:  if (cnt == BIAS_LAST) state_nxt = S_MAC;
      S_MAC:   if (cnt == MAC_LAST) state_nxt = S_WRITE;
      S_WRITE: if (lane == LANE_LAST) state_nxt = (g == G_LAST) ? S_DONE : S_BIAS;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    for (int l = 0; l < LANES; l++)
      prod[l] = $signed(x_data) * $signed(w_data[l*DW +: DW]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      lane    <= '0;
      g       <= '0;
      relu_q  <= 1'b0;
      round_q <= 1'b0;
      shift_q <= '0;
      x_addr  <= '0;
      w_addr  <= '0;
      b_addr  <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            relu_q  <= relu_en;
            round_q <= round_en;
            shift_q <= shift_right;
            g       <= '0;
            b_addr  <= '0;
            cnt     <= '0;
          end
        end
        S_BIAS: begin
          if (cnt == BIAS_LAST) begin
            for (int l = 0; l < LANES; l++)
              acc[l] <= ACC_W'($signed(b_data[l*BW +: BW]));
            x_addr <= '0;
            w_addr <= WAW'(g) * WAW'(IN_DIM);
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MAC: begin
          // Data returning now belongs to the address issued RD_LAT cycles ago.
          if (cnt >= RDL) begin
            for (int l = 0; l < LANES; l++)
              acc[l] <= acc[l] + ACC_W'(prod[l]);
          end
          if (cnt < ADDR_LAST) begin
            x_addr <= x_addr + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
          if (cnt == MAC_LAST) begin
            cnt  <= '0;
            lane <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (lane == LANE_LAST) begin
            lane <= '0;
            if (g != G_LAST) begin
              g      <= g + 1'b1;
              b_addr <= g + 1'b1;
            end
          end else begin
            lane <= lane + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Post-processing at ACC_W+1 bits so the rounding increment cannot wrap.
  always_comb begin
    acc_sel = acc[lane];
    ext     = EW'(acc_sel);
    rnd     = ext;
    if (round_q && shift_q != 6'd0 && int'(shift_q) <= ACC_W)
      rnd = ext + (EW'(1) <<< (shift_q - 6'd1));
    shf = rnd >>> shift_q;
    // A rounded shift past the accumulator width always lands on zero.
    if (round_q && int'(shift_q) > ACC_W)
      shf = '0;
    if (shf > Y_MAX)      post_y = Y_MAX[DW-1:0];
    else if (shf < Y_MIN) post_y = Y_MIN[DW-1:0];
    else                  post_y = shf[DW-1:0];
    if (relu_q && post_y[DW-1])
      post_y = '0;
  end

  always_comb begin
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    y_we   = (state == S_WRITE);
    y_addr = '0;
    y_data = '0;
    if (state == S_WRITE) begin
      y_addr = YAW'(g) * YAW'(LANES) + YAW'(lane);
      y_data = post_y;
    end
  end

endmodule

// File: tb/tb_fc_layer_par.sv
// Scoreboard bench for fc_layer_par: IN_DIM=4, OUT_DIM=4, LANES=2, run with RD_LAT=1 and RD_LAT=2 side by side.
module tb_fc_layer_par;

  logic       clk = 1'b0;
  logic       rst, start, relu_en, round_en;
  logic [5:0] shift_right;

  logic        busy1, done1, y_we1, busy2, done2, y_we2;
  logic [1:0]  x_addr1, y_addr1, x_addr2, y_addr2;
  logic [2:0]  w_addr1, w_addr2;
  logic [0:0]  b_addr1, b_addr2;
  logic [7:0]  x_data1, y_data1, x_data2, y_data2, xs2;
  logic [15:0] w_data1, w_data2, ws2;
  logic [63:0] b_data1, b_data2, bs2;

  logic [7:0]  xm [4];
  logic [15:0] wm [8];
  logic [63:0] bm [2];

  int xv [4];
  int wv [4][4];
  int bv [4];
  int exp_y [4];

  logic [9:0] q1 [$];
  logic [9:0] q2 [$];
  logic [9:0] e1, e2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fc_layer_par #(.IN_DIM(4), .OUT_DIM(4), .LANES(2), .DW(8), .BW(32), .ACC_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .round_en(round_en),
    .shift_right(shift_right), .busy(busy1), .done(done1),
    .x_addr(x_addr1), .x_data(x_data1), .w_addr(w_addr1), .w_data(w_data1),
    .b_addr(b_addr1), .b_data(b_data1), .y_we(y_we1), .y_addr(y_addr1), .y_data(y_data1)
  );

  fc_layer_par #(.IN_DIM(4), .OUT_DIM(4), .LANES(2), .DW(8), .BW(32), .ACC_W(32), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .round_en(round_en),
    .shift_right(shift_right), .busy(busy2), .done(done2),
    .x_addr(x_addr2), .x_data(x_data2), .w_addr(w_addr2), .w_data(w_data2),
    .b_addr(b_addr2), .b_data(b_data2), .y_we(y_we2), .y_addr(y_addr2), .y_data(y_data2)
  );

  // Synchronous read memories, one and two cycles of latency.
  always @(posedge clk) begin
    x_data1 <= xm[x_addr1];
    w_data1 <= wm[w_addr1];
    b_data1 <= bm[b_addr1];
    xs2     <= xm[x_addr2];
    ws2     <= wm[w_addr2];
    bs2     <= bm[b_addr2];
    x_data2 <= xs2;
    w_data2 <= ws2;
    b_data2 <= bs2;
  end

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: every write strobe pops the next expected (addr, data).
  always @(negedge clk) begin
    if (y_we1) begin
      if (q1.size() == 0) chk("y1_unexpected_write", int'(y_addr1), -1);
      else begin
        e1 = q1.pop_front();
        chk("y1_addr", int'(y_addr1), int'(e1[9:8]));
        chk("y1_data", int'($signed(y_data1)), int'($signed(e1[7:0])));
      end
    end
    if (y_we2) begin
      if (q2.size() == 0) chk("y2_unexpected_write", int'(y_addr2), -1);
      else begin
        e2 = q2.pop_front();
        chk("y2_addr", int'(y_addr2), int'(e2[9:8]));
        chk("y2_data", int'($signed(y_data2)), int'($signed(e2[7:0])));
      end
    end
  end

  task automatic load_mem();
    for (int i = 0; i < 4; i++) xm[i] = 8'(xv[i]);
    for (int g = 0; g < 2; g++) begin
      bm[g] = {32'(bv[2*g+1]), 32'(bv[2*g])};
      for (int k = 0; k < 4; k++) wm[g*4+k] = {8'(wv[2*g+1][k]), 8'(wv[2*g][k])};
    end
  endtask

  task automatic set_uniform(input int xval, input int wval, input int bval);
    for (int i = 0; i < 4; i++) begin
      xv[i] = xval;
      bv[i] = bval;
      for (int k = 0; k < 4; k++) wv[i][k] = wval;
    end
    load_mem();
  endtask

  task automatic set_s1();
    xv = '{1, 2, 3, 4};
    wv = '{'{1, 1, 1, 1}, '{2, 0, -1, 0}, '{0, 0, 0, 1}, '{-1, 0, 0, 2}};
    bv = '{5, 10, -20, 0};
    load_mem();
    exp_y = '{15, 9, 0, 7};
  endtask

  // mode: 0 plain, 1 start pulse mid-MAC, 2 shift change mid-pass, 3 reset mid-MAC.
  task automatic run_pass(input logic re, input logic ro, input logic [5:0] sh, input int mode);
    int d1, d2, nd1, nd2, bz1, bz2;
    int ed1, ed2, end_n;
    d1 = 0; d2 = 0; nd1 = 0; nd2 = 0; bz1 = -1; bz2 = -1;
    ed1 = (mode == 3) ? 0 : 19;
    ed2 = (mode == 3) ? 0 : 23;
    end_n = (mode == 3) ? 0 : 1;
    if (mode != 3) begin
      for (int i = 0; i < 4; i++) begin
        q1.push_back({2'(i), 8'(exp_y[i])});
        q2.push_back({2'(i), 8'(exp_y[i])});
      end
    end
    @(negedge clk);
    relu_en = re; round_en = ro; shift_right = sh; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done1) begin nd1++; if (d1 == 0) d1 = n; end
      if (done2) begin nd2++; if (d2 == 0) d2 = n; end
      if (d1 != 0 && n == d1 + 1) bz1 = int'(busy1);
      if (d2 != 0 && n == d2 + 1) bz2 = int'(busy2);
      if (mode == 3 && n == 6) begin
        chk("rst_y_we1", int'(y_we1), 0);
        chk("rst_busy1", int'(busy1), 0);
        chk("rst_y_we2", int'(y_we2), 0);
        chk("rst_busy2", int'(busy2), 0);
      end
      if (n == 5) begin
        if (mode == 1) start = 1'b1;
        if (mode == 2) shift_right = 6'd3;
        if (mode == 3) rst = 1'b1;
      end
      if (n == 6) begin
        start = 1'b0;
        rst   = 1'b0;
      end
    end
    chk("done_cycle1", d1, ed1);
    chk("done_cycle2", d2, ed2);
    chk("done_count1", nd1, end_n);
    chk("done_count2", nd2, end_n);
    if (mode != 3) begin
      chk("busy_after_done1", bz1, 0);
      chk("busy_after_done2", bz2, 0);
    end
    chk("pending_writes1", q1.size(), 0);
    chk("pending_writes2", q2.size(), 0);
    q1.delete();
    q2.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; round_en = 1'b0; shift_right = 6'd0;
    set_uniform(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs1", int'({busy1, done1, y_we1, x_addr1, w_addr1, b_addr1, y_addr1, y_data1}), 0);
    chk("reset_outs2", int'({busy2, done2, y_we2, x_addr2, w_addr2, b_addr2, y_addr2, y_data2}), 0);
    rst = 1'b0;

    // Dot product with bias and ReLU
    set_s1();
    run_pass(1'b1, 1'b0, 6'd0, 0);

    // Saturation high, low, and low clipped by ReLU
    set_uniform(127, 127, 0);
    exp_y = '{127, 127, 127, 127};
    run_pass(1'b1, 1'b0, 6'd0, 0);
    set_uniform(127, -127, 0);
    exp_y = '{-128, -128, -128, -128};
    run_pass(1'b0, 1'b0, 6'd0, 0);
    exp_y = '{0, 0, 0, 0};
    run_pass(1'b1, 1'b0, 6'd0, 0);

    // Rounding on positive and negative values
    set_uniform(0, 0, 6);
    exp_y = '{1, 1, 1, 1};
    run_pass(1'b0, 1'b0, 6'd2, 0);
    exp_y = '{2, 2, 2, 2};
    run_pass(1'b0, 1'b1, 6'd2, 0);
    set_uniform(0, 0, -6);
    exp_y = '{-1, -1, -1, -1};
    run_pass(1'b0, 1'b1, 6'd2, 0);
    exp_y = '{-2, -2, -2, -2};
    run_pass(1'b0, 1'b0, 6'd2, 0);

    // Robustness: ignored start, latched shift, reset abort then clean rerun
    set_s1();
    run_pass(1'b1, 1'b0, 6'd0, 1);
    run_pass(1'b1, 1'b0, 6'd0, 2);
    run_pass(1'b1, 1'b0, 6'd0, 3);
    run_pass(1'b1, 1'b0, 6'd0, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_layer_par.md
# fc_layer_par

Parameterised, multi-lane fully-connected layer engine for the MNIST inference datapath. It computes `y = post(W·x + b)` for `OUT_DIM` neurons over `IN_DIM` int inputs, with `LANES` neurons accumulated in parallel per pass. Post-processing is a configurable arithmetic right shift, with optional round-to-nearest, saturation to `DW` bits and optional ReLU. It reads activations, packed weights and packed biases from external synchronous memories with configurable read latency, and writes results one neuron per cycle through a write port. It replaces single-lane fixed-width FC layers for both hidden and output layers.

## Interface
- `IN_DIM`, 784, number of input activations.
- `OUT_DIM`, 32, number of output neurons; must be a multiple of `LANES`.
- `LANES`, 4, neurons accumulated in parallel.
- `DW`, 8, signed activation, weight and output width.
- `BW`, 32, signed bias width.
- `ACC_W`, 32, signed accumulator width; must be ≥ `BW` and ≥ 2·`DW`.
- `RD_LAT`, 1, read latency (≥1) of all three read memories.
- `G` (localparam) = `OUT_DIM/LANES`, the number of neuron groups.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a layer pass; honoured only in IDLE.
- `relu_en`  in  1  zero negative outputs.
- `round_en`  in  1  add `2^(shift_right-1)` before shifting, when `shift_right` > 0.
- `shift_right`  in  6  arithmetic right shift amount.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `x_addr`  out  clog2(`IN_DIM`)  activation index k.
- `x_data`  in  `DW`  signed `x[k]`.
- `w_addr`  out  clog2(`G`·`IN_DIM`)  value g·`IN_DIM`+k.
- `w_data`  in  `LANES`·`DW`  lane l in bits [l·DW +: DW] holds `W[g·LANES+l][k]`.
- `b_addr`  out  clog2(`G`)  group g.
- `b_data`  in  `LANES`·`BW`  lane l holds `b[g·LANES+l]`.
- `y_we`  out  1  write strobe.
- `y_addr`  out  clog2(`OUT_DIM`)  neuron index.
- `y_data`  out  `DW`  signed result.

## Operation
- **Reset:** state IDLE. All outputs are 0: `busy`, `done`, `y_we`, all addresses, `y_data`. Accumulators and counters are cleared.
- **Reset mid-pass:** aborts the pass with no further writes. A following `start` runs a complete, correct pass.
- **Memory reads:** all address outputs are registered. Data for the address presented in cycle t is consumed in cycle t+`RD_LAT`.
- **Mode latching:** `relu_en`, `round_en` and `shift_right` are latched when `start` is accepted. Changes during a pass have no effect.
- **IDLE:**
  - On `start`: latch the mode inputs, set g=0, drive `b_addr`=0, go to BIAS.
  - `start` in any other state is ignored.
- **BIAS (`RD_LAT`+1 cycles):**
  - Hold `b_addr`=g.
  - On the last cycle, load `acc[l]` = sign-extended `b_data` lane l.
  - Drive `x_addr`=0 and `w_addr`=g·`IN_DIM`, then go to MAC.
- **MAC (`IN_DIM`+`RD_LAT` cycles):**
  - Addresses for k = 0..`IN_DIM`-1 are presented on consecutive MAC cycles.
  - In MAC cycle k+`RD_LAT`: `acc[l]` += `x[k]`·`w_lane_l` (signed `DW`×`DW`, sign-extended to `ACC_W`).
  - Accumulation wraps modulo 2^`ACC_W`; there is no overflow detection.
  - Then go to WRITE.
- **WRITE (`LANES` cycles):**
  - Cycle l: `y_we`=1, `y_addr`=g·`LANES`+l, `y_data`=post(`acc[l]`).
  - After lane `LANES`-1: if g=`G`-1, go to DONE; otherwise g+=1, drive `b_addr`=g+1, go to BIAS.
- **post(a):**
  - If `round_en` and shift > 0, a += 2^(shift-1).
  - a >>>= shift (arithmetic).
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
  - If `relu_en` and the result is negative, output 0.
  - The rounding add is done at `ACC_W`+1 bits, so it cannot wrap.
- **DONE (1 cycle):** `done`=1, `busy`=1, then IDLE.

## Timing
- **Per-group cycles:** 2·`RD_LAT` + 1 + `IN_DIM` + `LANES`.
- **Pass latency:** if `start` is sampled at edge 0, the first BIAS cycle is cycle 1. `done` is high in cycle `G`·(2·`RD_LAT`+1+`IN_DIM`+`LANES`)+1, and `busy` falls in the next cycle.
- **Write strobe:** `y_we` is never high outside WRITE and is high for exactly `OUT_DIM` cycles per pass.
- **Write order:** `y_addr` is strictly increasing 0..`OUT_DIM`-1.
- **Back-to-back passes:** `start` held high through DONE begins a new pass in the cycle after `done` (the cycle in which IDLE samples it).

## Test plan
Configuration for all scenarios: `IN_DIM`=4, `OUT_DIM`=4, `LANES`=2, `DW`=8, `RD_LAT`=1. Scenario 4 also runs `RD_LAT`=2.

1. **Dot product:** x=[1,2,3,4], `W` row 0 =[1,1,1,1], row 3 =[-1,0,0,2], b0=5, b3=0, shift 0, ReLU on -> y[0]=15, y[3]=7.
2. **Saturation:** x=W=all 127, b=0, shift 0 -> all outputs 127. Change `W` to all -127 with ReLU off -> all -128. Same with ReLU on -> all 0.
3. **Rounding:** W=0, b=6, shift 2: round off -> 1, round on -> 2. With b=-6 and ReLU off: round on -> -1, round off -> -2.
4. **Latency:**
   - `RD_LAT`=1: `done` in cycle 19, and 4 `y_we` pulses with `y_addr` 0,1,2,3.
   - `RD_LAT`=2: `done` in cycle 23.
5. **Robustness:**
   - `start` pulsed mid-MAC is ignored and results match scenario 1.
   - `shift_right` changed mid-pass has no effect on results.
   - `rst` asserted during MAC: `y_we`=0 and `busy`=0 in the next cycle, and `done` is never asserted. A subsequent `start` reproduces the scenario 1 outputs exactly.
